// File: rtl/alu_sequencer.sv
// Sequencer that issues register-file commands to an external combinational ALU.
// It handles one command at a time: accept, issue to the ALU, then hold the result until taken.
module alu_sequencer #(
  parameter int unsigned bit_depth = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [1:0]           cmd_dst,
  input  logic [1:0]           cmd_srca,
  input  logic [1:0]           cmd_srcb,
  input  logic [bit_depth-1:0] cmd_imm,
  output logic [3:0]           alu_op,
  output logic [bit_depth-1:0] alu_a,
  output logic [bit_depth-1:0] alu_b,
  input  logic [bit_depth-1:0] alu_r,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [bit_depth-1:0] res_data,
  output logic [1:0]           res_dst,
  output logic                 res_zero,
  output logic                 res_err,
  input  logic [1:0]           rd_addr,
  output logic [bit_depth-1:0] rd_data
);

  localparam logic [3:0] OpLoadi = 4'hF;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e               state_q, state_d;
  logic [1:0]           dst_q;
  logic [bit_depth-1:0] imm_q;
  logic [bit_depth-1:0] rf_q [4];
  logic                 accept;
  logic                 op_legal;
  logic [bit_depth-1:0] capt;

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  if (res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    res_valid = (state_q == StResp);
  end

  // The latched op on alu_op doubles as the decode source during ISSUE.
  always_comb begin
    op_legal = (alu_op <= 4'd9) || (alu_op == OpLoadi);
    capt     = '0;
    if (alu_op == OpLoadi) begin
      capt = imm_q;
    end else if (op_legal) begin
      capt = alu_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      dst_q    <= '0;
      imm_q    <= '0;
      res_data <= '0;
      res_dst  <= '0;
      res_zero <= 1'b0;
      res_err  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        alu_op <= cmd_op;
        alu_a  <= rf_q[cmd_srca];
        alu_b  <= rf_q[cmd_srcb];
        dst_q  <= cmd_dst;
        imm_q  <= cmd_imm;
      end
      if (state_q == StIssue) begin
        res_data <= capt;
        res_dst  <= dst_q;
        res_zero <= (capt == '0);
        res_err  <= !op_legal;
        if (op_legal) begin
          rf_q[dst_q] <= capt;
        end
      end
    end
  end

  assign rd_data = rf_q[rd_addr];

endmodule
